// File: rtl/fft_pkg.sv
// Shared constants for the FFT front-end: default widths, legal frame lengths,
// error codes and the framing FSM state type.
package fft_pkg;

  localparam int DATA_W_DEF = 12;
  localparam int PTS_W_DEF  = 11;

  localparam int PTS_64   = 64;
  localparam int PTS_128  = 128;
  localparam int PTS_256  = 256;
  localparam int PTS_512  = 512;
  localparam int PTS_1024 = 1024;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_DROP = 2'b01;

  typedef enum logic {IDLE, STREAM} feed_state_e;

  function automatic logic pts_legal(input int unsigned pts);
    return (pts == PTS_64)  || (pts == PTS_128) || (pts == PTS_256) ||
           (pts == PTS_512) || (pts == PTS_1024);
  endfunction

endpackage

// File: rtl/fft_feed_fifo.sv
// Sample FIFO, DEPTH x W. Read data comes straight from the storage registers,
// so the consumer's output register is the only stage between head and port.
module fft_feed_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 12
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);

endmodule

// File: rtl/fft_frame_feeder.sv
// Frames a free-running sample stream into Avalon-ST packets for the FFT core.
// Define FFT_FEED_OFFSET_BIN_EN to accept offset-binary input (MSB flipped at the FIFO write).
module fft_frame_feeder
  import fft_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int PTS_W      = PTS_W_DEF,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PTS_W-1:0]  cfg_fftpts,
  output logic              src_valid,
  input  logic              src_ready,
  output logic              src_sop,
  output logic              src_eop,
  output logic [1:0]        src_error,
  output logic [DATA_W-1:0] src_real,
  output logic [DATA_W-1:0] src_imag,
  output logic [PTS_W-1:0]  src_fftpts,
  output logic              src_inverse,
  output logic              ovf_sticky,
  output logic              cfg_err
);

  feed_state_e       state, state_nxt;
  logic [PTS_W-1:0]  cnt, cnt_nxt, pts_nxt;
  logic              sop_nxt, eop_nxt, bad_cfg, drop_flag;
  logic [1:0]        err_nxt;
  logic              fifo_full, fifo_empty, load, wr, drop;
  logic [DATA_W-1:0] fifo_q, wr_data;

`ifdef FFT_FEED_OFFSET_BIN_EN
  assign wr_data = {~in_data[DATA_W-1], in_data[DATA_W-2:0]};
`else
  assign wr_data = in_data;
`endif

  // A read in the same cycle frees a slot, so a full FIFO still accepts.
  assign load = (!src_valid || src_ready) && !fifo_empty;
  assign wr   = in_valid && (!fifo_full || load);
  assign drop = in_valid && fifo_full && !load;

  fft_feed_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_W)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr),
    .wr_data (wr_data),
    .rd_en   (load),
    .rd_data (fifo_q),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pts_nxt   = src_fftpts;
    sop_nxt   = src_sop;
    eop_nxt   = src_eop;
    err_nxt   = src_error;
    bad_cfg   = 1'b0;
    if (src_ready) begin
      sop_nxt = 1'b0;
      eop_nxt = 1'b0;
      err_nxt = ERR_OK;
    end
    if (load) begin
      sop_nxt = 1'b0;
      eop_nxt = 1'b0;
      err_nxt = ERR_OK;
      case (state)
        IDLE: begin
          sop_nxt   = 1'b1;
          cnt_nxt   = PTS_W'(1);
          state_nxt = STREAM;
          if (pts_legal(32'(cfg_fftpts))) pts_nxt = cfg_fftpts;
          else                            bad_cfg = 1'b1;
        end
        STREAM: begin
          if (cnt == src_fftpts - PTS_W'(1)) begin
            eop_nxt   = 1'b1;
            err_nxt   = (drop_flag || drop) ? ERR_DROP : ERR_OK;
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt + PTS_W'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_valid  <= 1'b0;
      src_sop    <= 1'b0;
      src_eop    <= 1'b0;
      src_error  <= ERR_OK;
      src_real   <= '0;
      src_fftpts <= PTS_W'(PTS_1024);
      cnt        <= '0;
      drop_flag  <= 1'b0;
      ovf_sticky <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      if (load)           src_valid <= 1'b1;
      else if (src_ready) src_valid <= 1'b0;
      if (load) src_real <= fifo_q;
      src_sop    <= sop_nxt;
      src_eop    <= eop_nxt;
      src_error  <= err_nxt;
      src_fftpts <= pts_nxt;
      cnt        <= cnt_nxt;
      cfg_err    <= bad_cfg;
      // A drop in the eop-handshake cycle belongs to the following frame.
      if (drop)                                   drop_flag <= 1'b1;
      else if (src_valid && src_ready && src_eop) drop_flag <= 1'b0;
      if (drop) ovf_sticky <= 1'b1;
    end
  end

  assign src_imag    = '0;
  assign src_inverse = 1'b0;

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Self-checking bench for fft_frame_feeder: directed phases with random data,
// checked against a scoreboard of accepted samples and frame-length rules.
module tb_fft_frame_feeder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [11:0] in_data = '0;
  logic [10:0] cfg_fftpts = 11'd64;
  logic        src_ready = 1'b0;
  logic        src_valid, src_sop, src_eop, src_inverse, ovf_sticky, cfg_err;
  logic [1:0]  src_error;
  logic [11:0] src_real, src_imag;
  logic [10:0] src_fftpts;

  fft_frame_feeder dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .cfg_fftpts  (cfg_fftpts),
    .src_valid   (src_valid),
    .src_ready   (src_ready),
    .src_sop     (src_sop),
    .src_eop     (src_eop),
    .src_error   (src_error),
    .src_real    (src_real),
    .src_imag    (src_imag),
    .src_fftpts  (src_fftpts),
    .src_inverse (src_inverse),
    .ovf_sticky  (ovf_sticky),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [11:0] q[$];
  int          beat_idx = 0;
  int          model_pts = 1024;
  bit          allow_drop = 1'b0;
  bit          frame_gap = 1'b0;
  int          cfg_err_cnt = 0;
  int          drop_eops = 0;
  int          last_len = 0;
  int          frames = 0;
  bit          prev_stall = 1'b0;
  logic [27:0] prev_vec;
  logic [27:0] cur_vec;
  logic [11:0] exp_d;

  assign cur_vec = {src_valid, src_sop, src_eop, src_error, src_real, src_fftpts};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] model_sample(input logic [11:0] d);
`ifdef FFT_FEED_OFFSET_BIN_EN
    return d ^ 12'h800;
`else
    return d;
`endif
  endfunction

  function automatic bit legal(input int p);
    return (p == 64) || (p == 128) || (p == 256) || (p == 512) || (p == 1024);
  endfunction

  // Reference model: every accepted sample appears once, in order; frames are
  // model_pts long, with the length taken from cfg at each frame start.
  always @(negedge clk) begin
    if (!reset_n) begin
      q.delete();
      beat_idx   = 0;
      model_pts  = 1024;
      frame_gap  = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (cfg_err) cfg_err_cnt++;
      if (prev_stall) chk("hold", 32'(cur_vec), 32'(prev_vec));
      if (src_valid && src_ready) begin
        if (beat_idx == 0 && legal(int'(cfg_fftpts))) model_pts = int'(cfg_fftpts);
        chk("sop", 32'(src_sop), 32'(beat_idx == 0));
        chk("eop", 32'(src_eop), 32'(beat_idx == model_pts - 1));
        chk("fftpts", 32'(src_fftpts), model_pts);
        chk("imag_inv", 32'({src_imag, src_inverse}), 0);
        while (allow_drop && q.size() > 0 && q[0] !== src_real) begin
          void'(q.pop_front());
          frame_gap = 1'b1;
        end
        exp_d = 'x;
        if (q.size() > 0) exp_d = q.pop_front();
        chk("data", 32'(src_real), 32'(exp_d));
        if (beat_idx == model_pts - 1) begin
          chk("eop_error", 32'(src_error), frame_gap ? 1 : 0);
          if (src_error == 2'b01) drop_eops++;
          frame_gap = 1'b0;
          last_len  = beat_idx + 1;
          beat_idx  = 0;
          frames++;
        end else begin
          chk("mid_error", 32'(src_error), 0);
          beat_idx++;
        end
      end
      prev_stall = src_valid && !src_ready;
      prev_vec   = cur_vec;
      if (in_valid) q.push_back(model_sample(in_data));
    end
  end

  task automatic step(input logic v, input logic [11:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    src_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    chk("rst_outs", {src_valid, src_sop, src_eop, src_error, src_real, src_imag,
                     src_inverse, ovf_sticky, cfg_err}, 0);
    chk("rst_pts", 32'(src_fftpts), 1024);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Ramp, two 64-point frames, ready held high; check first-beat latency.
    for (int i = 0; i < 128; i++) begin
      step(1'b1, 12'(i), 1'b1);
      if (i == 0) chk("lat_t1", 32'(src_valid), 0);
      if (i == 1) chk("lat_t2", 32'(src_valid), 1);
    end
    repeat (8) step(1'b0, 12'h0, 1'b1);
    chk("t1_frames", frames, 2);
    chk("t1_drained", q.size(), 0);

    // Sparse input with ready 1-of-3, random data.
    for (int c = 0; c < 256; c++) step(c % 4 == 0, 12'($urandom), c % 3 == 0);
    repeat (20) step(1'b0, 12'h0, 1'b1);
    chk("t2_frames", frames, 3);
    chk("t2_drained", q.size(), 0);
    chk("t2_no_ovf", 32'(ovf_sticky), 0);

    // Illegal length at frame start, then a mid-frame change to 256.
    cfg_fftpts = 11'd100;
    for (int i = 0; i < 320; i++) begin
      if (i == 20) cfg_fftpts = 11'd256;
      step(1'b1, 12'($urandom), 1'b1);
    end
    repeat (8) step(1'b0, 12'h0, 1'b1);
    chk("t3_cfg_err_pulses", cfg_err_cnt, 1);
    chk("t3_frames", frames, 5);
    chk("t3_last_len", last_len, 256);
    chk("t3_drained", q.size(), 0);

    // Backpressure long enough to overflow the FIFO.
    cfg_fftpts = 11'd64;
    allow_drop = 1'b1;
    for (int i = 0; i < 40; i++)  step(1'b1, 12'(1000 + i), 1'b0);
    for (int i = 0; i < 120; i++) step(1'b1, 12'(1040 + i), 1'b1);
    repeat (40) step(1'b0, 12'h0, 1'b1);
    allow_drop = 1'b0;
    chk("t4_ovf", 32'(ovf_sticky), 1);
    chk("t4_drop_eops", drop_eops, 1);
    chk("t4_frames", frames, 7);

    // Reset in the middle of a frame.
    for (int i = 0; i < 200 && beat_idx != 30; i++) step(1'b1, 12'(2000 + i), 1'b1);
    chk("t5_beat30", beat_idx, 30);
    reset_n  = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("t5_rst_outs", {src_valid, src_sop, src_eop, src_error, src_real, src_imag,
                        src_inverse, ovf_sticky, cfg_err}, 0);
    chk("t5_rst_pts", 32'(src_fftpts), 1024);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Sign-boundary samples; the first beat after reset must be a sop.
    step(1'b1, 12'h800, 1'b1);
    step(1'b1, 12'hFFF, 1'b1);
    step(1'b1, 12'h000, 1'b1);
    repeat (6) step(1'b0, 12'h0, 1'b1);
    chk("t6_drained", q.size(), 0);
    chk("t6_beats", beat_idx, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
